// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the sequential 32x32 multiplier built on a 16x16 slice.
package mult_seq_pkg;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned FULL_W = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DRAIN,
        FIX,
        DONE
    } state_t;
endpackage

// File: rtl/mult_seq_ctrl_mul16_stage.sv
// 16x16 unsigned multiplier with MUL_LATENCY enabled register stages; data path carries no reset.
module mul16_stage
    import mult_seq_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    output logic [FULL_W-1:0] o_p
);
    logic [FULL_W-1:0] r_pipe [MUL_LATENCY];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_pipe[0] <= {{HALF_W{1'b0}}, i_a} * {{HALF_W{1'b0}}, i_b};
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_p = r_pipe[MUL_LATENCY-1];
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer issuing four 16x16 partial products to one shared slice, shift-accumulating them,
// then applying two's-complement correction for signed requests.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 1,
    parameter bit          SIGNED_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FULL_W-1:0] in_a,
    input  logic [FULL_W-1:0] in_b,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_result,
    output logic              busy
);
    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [1:0]        r_drain;
    logic [FULL_W-1:0] r_a;
    logic [FULL_W-1:0] r_b;
    logic              r_sgn;
    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_result;
    logic              r_out_valid;
    // Tags travel alongside the slice so each product is weighted by the half-pair that made it.
    logic              r_tag_v [MUL_LATENCY];
    logic [1:0]        r_tag_k [MUL_LATENCY];

    logic              w_mul_en;
    logic [HALF_W-1:0] w_op_a;
    logic [HALF_W-1:0] w_op_b;
    logic [FULL_W-1:0] w_prod;
    logic [PROD_W-1:0] w_addend;
    logic [PROD_W-1:0] w_corr;

    assign w_mul_en = (r_state == MUL) || (r_state == DRAIN);
    assign w_op_a   = r_cnt[1] ? r_a[FULL_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_op_b   = r_cnt[0] ? r_b[FULL_W-1:HALF_W] : r_b[HALF_W-1:0];

    mul16_stage #(
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mul (
        .clk (clk),
        .i_en(w_mul_en),
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_prod)
    );

    always_comb begin
        w_addend = '0;
        case (r_tag_k[MUL_LATENCY-1])
            2'd0:    w_addend = {{FULL_W{1'b0}}, w_prod};
            2'd3:    w_addend = {w_prod, {FULL_W{1'b0}}};
            default: w_addend = {{HALF_W{1'b0}}, w_prod, {HALF_W{1'b0}}};
        endcase
    end

    // Unsigned product minus the sign-bit weights of each operand gives the signed result mod 2^64.
    assign w_corr = (r_a[FULL_W-1] ? {r_b, {FULL_W{1'b0}}} : '0)
                  + (r_b[FULL_W-1] ? {r_a, {FULL_W{1'b0}}} : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sgn       <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                r_tag_v[i] <= 1'b0;
                r_tag_k[i] <= '0;
            end
        end else begin
            if (w_mul_en) begin
                r_tag_v[0] <= (r_state == MUL);
                r_tag_k[0] <= r_cnt;
                for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                    r_tag_v[i] <= r_tag_v[i-1];
                    r_tag_k[i] <= r_tag_k[i-1];
                end
                if (r_tag_v[MUL_LATENCY-1]) begin
                    r_acc <= r_acc + w_addend;
                end
            end

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_sgn   <= in_signed & SIGNED_EN;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_drain <= '0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_drain == 2'(MUL_LATENCY - 1)) begin
                        r_state <= FIX;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                FIX: begin
                    r_result    <= r_sgn ? (r_acc - w_corr) : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: two instances (MUL_LATENCY 1 and 2), vector table, corner sequences, random ops.
module tb_mult_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [31:0] in_a       [2];
    logic [31:0] in_b       [2];
    logic        in_signed  [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [63:0] out_result [2];
    logic        busy       [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_ctrl #(.MUL_LATENCY(1), .SIGNED_EN(1'b1)) dut0 (
        .clk(clk), .reset(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_signed(in_signed[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_result(out_result[0]), .busy(busy[0])
    );

    mult_seq_ctrl #(.MUL_LATENCY(2), .SIGNED_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_signed(in_signed[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_result(out_result[1]), .busy(busy[1])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    task automatic push_exp(input int d, input logic [63:0] e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int d, output logic [63:0] e, output bit ok);
        ok = 1'b1;
        e  = '0;
        if (d == 0) begin
            if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
        end else begin
            if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_in_ready"},  64'(in_ready[d]),  64'd1);
        chk({tag, "_busy"},      64'(busy[d]),      64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid[d]), 64'd0);
    endtask

    // Accepts one request, optionally pulses a stray request during MUL, waits for the result,
    // holds it with out_ready=0 for 'hold' cycles and then consumes it.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int hold, input bit pulse);
        int n;
        int e0;
        bit bad;
        bit ok;
        logic [63:0] want;
        logic [63:0] got;
        n = 0;
        while (!in_ready[d] && n < 100) begin
            step();
            n++;
        end
        chk("ready_before_accept", 64'(in_ready[d]), 64'd1);
        in_valid[d]  = 1'b1;
        in_a[d]      = a;
        in_b[d]      = b;
        in_signed[d] = s;
        push_exp(d, exp);
        step();
        e0 = cyc;
        in_valid[d]  = 1'b0;
        in_a[d]      = $urandom;
        in_b[d]      = $urandom;
        in_signed[d] = 1'($urandom_range(0, 1));
        bad = 1'b0;
        if (pulse) begin
            in_valid[d]  = 1'b1;
            in_a[d]      = 32'h1234;
            in_b[d]      = 32'h10;
            in_signed[d] = 1'b0;
            if (in_ready[d]) bad = 1'b1;
            step();
            in_valid[d] = 1'b0;
        end
        n = 0;
        while (!out_valid[d] && n < 20) begin
            if (in_ready[d]) bad = 1'b1;
            out_ready[d] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        out_ready[d] = 1'b0;
        if (in_ready[d]) bad = 1'b1;
        chk("in_ready_low_while_busy", 64'(bad), 64'd0);
        chk("out_valid_arrives", 64'(out_valid[d]), 64'd1);
        chk("latency", 64'(cyc - e0), (d == 0) ? 64'd6 : 64'd7);
        pop_exp(d, want, ok);
        chk("scoreboard_nonempty", 64'(ok), 64'd1);
        chk("result", out_result[d], want);
        got = out_result[d];
        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (!out_valid[d] || in_ready[d] || out_result[d] !== got) bad = 1'b1;
            end
            chk("hold_stable", 64'(bad), 64'd0);
        end
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        chk("valid_drop_after_accept", 64'(out_valid[d]), 64'd0);
        chk("ready_after_accept", 64'(in_ready[d]), 64'd1);
        chk("result_held_in_idle", out_result[d], got);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          r;

        tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        tbl[3] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
        tbl[4] = '{32'h0000_0007, 32'h0000_0006, 1'b0, 64'd42};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[6] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
        tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000};
        tbl[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
        tbl[9] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0};

        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_a[d]      = '0;
            in_b[d]      = '0;
            in_signed[d] = 1'b0;
            out_ready[d] = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            chk("reset_out_result", out_result[d], 64'h0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) begin
                run_op(d, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, i % 3, 1'b0);
            end
        end

        // Backpressure for 5 cycles with a stray request pulsed during MUL, then a real 0x1234*0x10.
        run_op(0, 32'd3, 32'd5, 1'b0, 64'd15, 5, 1'b1);
        check_idle(0, "after_stray");
        run_op(0, 32'h1234, 32'h10, 1'b0, 64'h12340, 0, 1'b0);

        // Reset while in MUL with cnt=2.
        in_valid[0]  = 1'b1;
        in_a[0]      = 32'hFFFF_FFFF;
        in_b[0]      = 32'hFFFF_FFFF;
        in_signed[0] = 1'b0;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle(0, "mid_reset");
        chk("mid_reset_out_result", out_result[0], 64'h0);
        r = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid[0]) r = 1;
            step();
        end
        chk("no_partial_valid", 64'(r), 64'd0);
        run_op(0, 32'd7, 32'd6, 1'b0, 64'd42, 0, 1'b0);
        run_op(1, 32'd7, 32'd6, 1'b0, 64'd42, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 7 == 0) ra = 32'h8000_0000;
            if (i % 11 == 0) rb = 32'hFFFF_FFFF;
            run_op(i % 2, ra, rb, rs, ref_mul(ra, rb, rs), int'($urandom_range(0, 3)), 1'b0);
        end

        chk("scoreboard_drained_0", 64'(q0.size()), 64'd0);
        chk("scoreboard_drained_1", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
